// File: rtl/sdram_pkg.sv
// ============================================================================
// Module : sdram_pkg
// Purpose: Shared definitions for the SDRAM Wishbone path. Holds the
//          arbiter state encoding and the Wishbone address/data widths,
//          which are also used by the SDRAM Wishbone adapter.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

  localparam int c_WB_ADDR_W = 32;
  localparam int c_WB_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

endpackage : sdram_pkg

`default_nettype wire

// File: rtl/sdram_wb_wdog.sv
// ============================================================================
// Module : sdram_wb_wdog
// Purpose: Bus watchdog. Counts cycles a strobe waits without an ack and
//          raises a one-cycle timeout once the wait reaches TIMEOUT.
// Ports  : clk     - clock, rising edge
//          reset   - asynchronous reset, active low
//          strobe  - owner's strobe, before any timeout gating
//          ack     - slave ack
//          timeout - combinational timeout pulse
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_wb_wdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic ack,
  output logic timeout
);

  localparam logic [15:0] c_LIMIT = 16'(TIMEOUT);

  logic [15:0] wd_cnt_q;
  logic [15:0] wd_cnt_d;

  // Saturating counter: once at the limit it holds, so it can never wrap.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!strobe || ack) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != c_LIMIT) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // An ack arriving in the limit cycle wins over the timeout.
  assign timeout = strobe & ~ack & (wd_cnt_q == c_LIMIT);

endmodule : sdram_wb_wdog

`default_nettype wire

// File: rtl/sdram_wb_arb.sv
// ============================================================================
// Module : sdram_wb_arb
// Purpose: Two-master Wishbone arbiter in front of the SDRAM data port.
//          M0 = control master, M1 = streaming master. Round-robin or
//          fixed-priority grant, bus locked for a whole Wishbone cycle,
//          watchdog terminates stalled transfers with an error.
// Ports  : clk, reset (async, active low)
//          m0_* / m1_*  - master-side Wishbone ports
//          s_*          - slave-side Wishbone port
//          grant        - one-hot owner (01 = M0, 10 = M1, 00 = idle)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_wb_arb
  import sdram_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0,
  parameter int TIMEOUT    = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [c_WB_ADDR_W-1:0] m0_address,
  input  logic [c_WB_DATA_W-1:0] m0_writedata,
  output logic [c_WB_DATA_W-1:0] m0_readdata,
  input  logic                   m0_strobe,
  input  logic                   m0_cycle,
  input  logic                   m0_write,
  output logic                   m0_ack,
  output logic                   m0_err,
  input  logic [c_WB_ADDR_W-1:0] m1_address,
  input  logic [c_WB_DATA_W-1:0] m1_writedata,
  output logic [c_WB_DATA_W-1:0] m1_readdata,
  input  logic                   m1_strobe,
  input  logic                   m1_cycle,
  input  logic                   m1_write,
  output logic                   m1_ack,
  output logic                   m1_err,
  output logic [c_WB_ADDR_W-1:0] s_address,
  output logic [c_WB_DATA_W-1:0] s_writedata,
  input  logic [c_WB_DATA_W-1:0] s_readdata,
  output logic                   s_strobe,
  output logic                   s_cycle,
  output logic                   s_write,
  input  logic                   s_ack,
  output logic [1:0]             grant
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;  // 0 = M0, 1 = M1
  logic       w_own_stb;
  logic       w_timeout;

  // Owner's raw strobe feeds the watchdog; the timeout gating of s_strobe
  // happens downstream so there is no combinational loop.
  assign w_own_stb = (state_q == ARB_OWN0) ? m0_strobe :
                     (state_q == ARB_OWN1) ? m1_strobe : 1'b0;

  sdram_wb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .strobe  (w_own_stb),
    .ack     (s_ack),
    .timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign grant = {state_q == ARB_OWN1, state_q == ARB_OWN0};

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    s_address    = '0;
    s_writedata  = '0;
    s_strobe     = 1'b0;
    s_cycle      = 1'b0;
    s_write      = 1'b0;
    m0_readdata  = '0;
    m1_readdata  = '0;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    m0_err       = 1'b0;
    m1_err       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Slave acks seen here belong to nobody and are dropped.
        if (m0_cycle && m1_cycle) begin
          if (PRIO_FIXED || last_owner_q) begin
            state_d = ARB_OWN0;
          end else begin
            state_d = ARB_OWN1;
          end
        end else if (m0_cycle) begin
          state_d = ARB_OWN0;
        end else if (m1_cycle) begin
          state_d = ARB_OWN1;
        end
      end

      ARB_OWN0: begin
        s_address   = m0_address;
        s_writedata = m0_writedata;
        s_write     = m0_write;
        s_cycle     = m0_cycle & ~w_timeout;
        s_strobe    = m0_strobe & ~w_timeout;
        m0_readdata = s_readdata;
        m0_ack      = s_ack & m0_strobe & ~w_timeout;
        m0_err      = w_timeout;
        if (w_timeout || !m0_cycle) begin
          state_d      = ARB_IDLE;
          last_owner_d = 1'b0;
        end
      end

      ARB_OWN1: begin
        s_address   = m1_address;
        s_writedata = m1_writedata;
        s_write     = m1_write;
        s_cycle     = m1_cycle & ~w_timeout;
        s_strobe    = m1_strobe & ~w_timeout;
        m1_readdata = s_readdata;
        m1_ack      = s_ack & m1_strobe & ~w_timeout;
        m1_err      = w_timeout;
        if (w_timeout || !m1_cycle) begin
          state_d      = ARB_IDLE;
          last_owner_d = 1'b1;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule : sdram_wb_arb

`default_nettype wire

// File: tb/tb_sdram_wb_arb.sv
// ============================================================================
// Module : tb_sdram_wb_arb
// Purpose: Self-checking bench for sdram_wb_arb. Two instances share all
//          inputs: dut (round-robin) and dut_f (fixed priority), both with
//          a 15-cycle watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdram_wb_arb;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [15:0] D0 = 16'h1234;
  localparam logic [15:0] D1 = 16'h0BEE;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_address = A0, m1_address = A1;
  logic [15:0] m0_writedata = D0, m1_writedata = D1;
  logic        m0_strobe = 0, m0_cycle = 0, m0_write = 1'b1;
  logic        m1_strobe = 0, m1_cycle = 0, m1_write = 1'b0;
  logic [15:0] s_readdata = '0;
  logic        s_ack = 1'b0;

  logic [15:0] m0_readdata, m1_readdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] s_address;
  logic [15:0] s_writedata;
  logic        s_strobe, s_cycle, s_write;
  logic [1:0]  grant;

  logic [15:0] f_m0_readdata, f_m1_readdata;
  logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
  logic [31:0] f_s_address;
  logic [15:0] f_s_writedata;
  logic        f_s_strobe, f_s_cycle, f_s_write;
  logic [1:0]  f_grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdram_wb_arb #(.PRIO_FIXED(1'b0), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_strobe(m0_strobe), .m0_cycle(m0_cycle), .m0_write(m0_write),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_strobe(m1_strobe), .m1_cycle(m1_cycle), .m1_write(m1_write),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_strobe(s_strobe), .s_cycle(s_cycle), .s_write(s_write), .s_ack(s_ack),
    .grant(grant)
  );

  sdram_wb_arb #(.PRIO_FIXED(1'b1), .TIMEOUT(15)) dut_f (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_readdata(f_m0_readdata),
    .m0_strobe(m0_strobe), .m0_cycle(m0_cycle), .m0_write(m0_write),
    .m0_ack(f_m0_ack), .m0_err(f_m0_err),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_readdata(f_m1_readdata),
    .m1_strobe(m1_strobe), .m1_cycle(m1_cycle), .m1_write(m1_write),
    .m1_ack(f_m1_ack), .m1_err(f_m1_err),
    .s_address(f_s_address), .s_writedata(f_s_writedata), .s_readdata(s_readdata),
    .s_strobe(f_s_strobe), .s_cycle(f_s_cycle), .s_write(f_s_write), .s_ack(s_ack),
    .grant(f_grant)
  );

  typedef struct {
    logic        m0c, m0s, m1c, m1s, sack;
    logic [15:0] srd;
    logic [1:0]  grant, fgrant;
    logic        sstb, scyc, swe;
    logic [31:0] saddr;
    logic [15:0] swd;
    logic        m0ack, m1ack;
    logic [15:0] m0rd, m1rd;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c0, s0, c1, s1, ack, input logic [15:0] rd);
    m0_cycle = c0; m0_strobe = s0; m1_cycle = c1; m1_strobe = s1;
    s_ack = ack; s_readdata = rd;
  endtask

  initial begin
    // Round-robin / fixed-priority ties, idle ack, then single M0 write.
    vecs[0]  = '{0,0,0,0,0,16'h0,    2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};
    vecs[1]  = '{1,1,1,1,0,16'h0,    2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};
    vecs[2]  = '{1,1,1,1,1,16'h1111, 2'b01,2'b01, 1,1,1, A0,D0, 1,0,16'h1111,16'h0};
    vecs[3]  = '{0,0,1,1,0,16'h0,    2'b01,2'b01, 0,0,1, A0,D0, 0,0,16'h0,16'h0};
    vecs[4]  = '{1,1,1,1,0,16'h0,    2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};
    vecs[5]  = '{1,1,1,1,1,16'h2222, 2'b10,2'b01, 1,1,0, A1,D1, 0,1,16'h0,16'h2222};
    vecs[6]  = '{0,0,0,0,0,16'h0,    2'b10,2'b01, 0,0,0, A1,D1, 0,0,16'h0,16'h0};
    vecs[7]  = '{0,0,0,0,1,16'h7777, 2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};
    vecs[8]  = '{1,1,1,1,0,16'h0,    2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};
    vecs[9]  = '{1,1,1,1,1,16'h3333, 2'b01,2'b01, 1,1,1, A0,D0, 1,0,16'h3333,16'h0};
    vecs[10] = '{0,0,1,1,0,16'h0,    2'b01,2'b01, 0,0,1, A0,D0, 0,0,16'h0,16'h0};
    vecs[11] = '{0,0,1,1,0,16'h0,    2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};
    vecs[12] = '{0,0,1,1,0,16'h0,    2'b10,2'b10, 1,1,0, A1,D1, 0,0,16'h0,16'h0};
    vecs[13] = '{0,0,0,0,0,16'h0,    2'b10,2'b10, 0,0,0, A1,D1, 0,0,16'h0,16'h0};
    vecs[14] = '{0,0,0,0,0,16'h0,    2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};
    vecs[15] = '{1,1,0,0,0,16'h0,    2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};
    vecs[16] = '{1,1,0,0,0,16'h0,    2'b01,2'b01, 1,1,1, A0,D0, 0,0,16'h0,16'h0};
    vecs[17] = '{1,1,0,0,0,16'h0,    2'b01,2'b01, 1,1,1, A0,D0, 0,0,16'h0,16'h0};
    vecs[18] = '{1,1,0,0,0,16'h0,    2'b01,2'b01, 1,1,1, A0,D0, 0,0,16'h0,16'h0};
    vecs[19] = '{1,1,0,0,1,16'h5555, 2'b01,2'b01, 1,1,1, A0,D0, 1,0,16'h5555,16'h0};
    vecs[20] = '{0,0,0,0,0,16'h0,    2'b01,2'b01, 0,0,1, A0,D0, 0,0,16'h0,16'h0};
    vecs[21] = '{0,0,0,0,0,16'h0,    2'b00,2'b00, 0,0,0, 32'h0,16'h0, 0,0,16'h0,16'h0};

    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i].m0c, vecs[i].m0s, vecs[i].m1c, vecs[i].m1s, vecs[i].sack, vecs[i].srd);
      #1;
      chk($sformatf("v%0d grant", i),   32'(grant),       32'(vecs[i].grant));
      chk($sformatf("v%0d fgrant", i),  32'(f_grant),     32'(vecs[i].fgrant));
      chk($sformatf("v%0d s_strobe", i),32'(s_strobe),    32'(vecs[i].sstb));
      chk($sformatf("v%0d s_cycle", i), 32'(s_cycle),     32'(vecs[i].scyc));
      chk($sformatf("v%0d s_write", i), 32'(s_write),     32'(vecs[i].swe));
      chk($sformatf("v%0d s_addr", i),  s_address,        vecs[i].saddr);
      chk($sformatf("v%0d s_wdata", i), 32'(s_writedata), 32'(vecs[i].swd));
      chk($sformatf("v%0d m0_ack", i),  32'(m0_ack),      32'(vecs[i].m0ack));
      chk($sformatf("v%0d m1_ack", i),  32'(m1_ack),      32'(vecs[i].m1ack));
      chk($sformatf("v%0d m0_rd", i),   32'(m0_readdata), 32'(vecs[i].m0rd));
      chk($sformatf("v%0d m1_rd", i),   32'(m1_readdata), 32'(vecs[i].m1rd));
      chk($sformatf("v%0d m0_err", i),  32'(m0_err),      32'h0);
      chk($sformatf("v%0d m1_err", i),  32'(m1_err),      32'h0);
    end

    // Block lock: M1 keeps the bus for 4 back-to-back reads while M0 waits.
    @(negedge clk);
    drive(1, 1, 1, 1, 0, 16'h0);
    #1 chk("blk idle grant", 32'(grant), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 1, 1, 1, 1, 16'hA000 + 16'(k));
      #1;
      chk($sformatf("blk%0d grant", k), 32'(grant), 32'h2);
      chk($sformatf("blk%0d m1_ack", k), 32'(m1_ack), 32'h1);
      chk($sformatf("blk%0d m1_rd", k), 32'(m1_readdata), 32'hA000 + k);
      chk($sformatf("blk%0d m0_ack", k), 32'(m0_ack), 32'h0);
    end
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 16'h0);
    #1 chk("blk drop grant", 32'(grant), 32'h2);
    chk("blk drop s_cycle", 32'(s_cycle), 32'h0);
    @(negedge clk); #1 chk("blk pass idle", 32'(grant), 32'h0);
    @(negedge clk); #1 chk("blk m0 granted", 32'(grant), 32'h1);
    chk("blk m0 addr", s_address, A0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 16'h0);
    @(negedge clk); #1 chk("blk end idle", 32'(grant), 32'h0);

    // Ack arriving in the same cycle the watchdog would fire counts as ack.
    drive(1, 1, 0, 0, 0, 16'h0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      s_ack = (c == 16);
      #1;
      chk($sformatf("wda%0d m0_err", c), 32'(m0_err), 32'h0);
      chk($sformatf("wda%0d m0_ack", c), 32'(m0_ack), (c == 16) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 16'h0);
    @(negedge clk); #1 chk("wda idle", 32'(grant), 32'h0);

    // Watchdog: slave never acks, M1 waits behind M0.
    drive(1, 1, 0, 0, 0, 16'h0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        m1_cycle = 1'b1; m1_strobe = 1'b1;
      end
      #1;
      chk($sformatf("wd%0d m0_err", c), 32'(m0_err), (c == 16) ? 32'h1 : 32'h0);
      chk($sformatf("wd%0d s_strobe", c), 32'(s_strobe), (c == 16) ? 32'h0 : 32'h1);
      if (c == 16) begin
        chk("wd16 s_cycle", 32'(s_cycle), 32'h0);
        chk("wd16 m0_ack", 32'(m0_ack), 32'h0);
        chk("wd16 grant", 32'(grant), 32'h1);
      end
    end
    @(negedge clk); #1;
    chk("wd after grant", 32'(grant), 32'h0);
    chk("wd after err", 32'(m0_err), 32'h0);
    @(negedge clk);
    m0_cycle = 1'b0; m0_strobe = 1'b0;
    #1 chk("wd m1 granted", 32'(grant), 32'h2);
    chk("wd m1 addr", s_address, A1);

    // Asynchronous reset in the middle of an M1 transfer.
    @(negedge clk);
    s_ack = 1'b1; s_readdata = 16'hCAFE;
    #1 chk("rst pre m1_ack", 32'(m1_ack), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst s_strobe", 32'(s_strobe), 32'h0);
    chk("rst s_cycle", 32'(s_cycle), 32'h0);
    chk("rst s_addr", s_address, 32'h0);
    chk("rst m1_ack", 32'(m1_ack), 32'h0);
    chk("rst m1_rd", 32'(m1_readdata), 32'h0);
    chk("rst m1_err", 32'(m1_err), 32'h0);
    @(negedge clk);
    reset = 1'b1; s_ack = 1'b0; s_readdata = '0;
    @(negedge clk); #1;
    chk("rst after grant", 32'(grant), 32'h2);
    chk("rst after s_strobe", 32'(s_strobe), 32'h1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 16'h0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sdram_wb_arb

`default_nettype wire
